// File: rtl/gaussian_blur_stream.sv
// Streaming KSIZE x KSIZE binomial blur, one pixel per cycle.
// Raster FIFO in, registered FIFO push out, border mode held per frame.
module gaussian_blur_stream #(
  parameter int WIDTH   = 1280,
  parameter int HEIGHT  = 720,
  parameter int PIXEL_W = 8,
  parameter int KSIZE   = 5
) (
  input  logic               clock,
  input  logic               reset,
  output logic               in_rd_en,
  input  logic               in_empty,
  input  logic [PIXEL_W-1:0] in_dout,
  output logic               out_wr_en,
  input  logic               out_full,
  output logic [PIXEL_W-1:0] out_din,
  input  logic [1:0]         mode,
  output logic               frame_done
);

  localparam int R     = (KSIZE - 1) / 2;
  localparam int D     = R * WIDTH + R;
  localparam int SR_N  = (KSIZE - 1) * WIDTH + KSIZE - 1;
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int NUM_W = PIXEL_W + 8;
  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = $clog2(HEIGHT);
  localparam int PW    = $clog2(NPIX);
  localparam int IW    = $clog2(SR_N + 1);
  localparam logic [7:0] TOTAL = (KSIZE == 5) ? 8'd159 : 8'd16;
  localparam logic [PIXEL_W-1:0] PMAX = '1;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t             state;
  logic [1:0]         mode_q;
  logic [PW-1:0]      pix_cnt;
  logic [RW-1:0]      row;
  logic [CW-1:0]      col;
  logic               out_valid;
  logic               out_last;
  logic               go_out;
  logic               adv;
  logic               load;
  logic               at_end;
  logic [PIXEL_W-1:0] in_px;
  logic [PIXEL_W-1:0] sr  [SR_N];
  logic [PIXEL_W-1:0] win [SR_N+1];
  logic [NUM_W-1:0]   num;
  logic [NUM_W-1:0]   quo;
  logic [7:0]         den;
  logic [7:0]         w;
  logic [IW-1:0]      idx;
  logic [PIXEL_W-1:0] blur;
  logic [PIXEL_W-1:0] result;
  int                 rr;
  int                 cc;

  function automatic logic [7:0] wgt(input int i, input int j);
    int a;
    int b;
    a = (2 * i < KSIZE) ? i : KSIZE - 1 - i;
    b = (2 * j < KSIZE) ? j : KSIZE - 1 - j;
    if (KSIZE == 3) return 8'd1 << (a + b);
    case (a * 3 + b)
      0:       return 8'd2;
      1, 3:    return 8'd4;
      2, 6:    return 8'd5;
      4:       return 8'd9;
      5, 7:    return 8'd12;
      default: return 8'd15;
    endcase
  endfunction

  assign at_end     = (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));
  assign go_out     = !out_valid || !out_full;
  assign adv        = (state == FLUSH) ? go_out
                    : !in_empty && (state == FILL || go_out);
  assign load       = adv && (state != FILL);
  assign in_rd_en   = adv && (state != FLUSH) && !reset;
  assign out_wr_en  = out_valid && !out_full;
  assign frame_done = out_wr_en && out_last;
  assign in_px      = (state == FLUSH) ? '0 : in_dout;

  // win is the window after this cycle's shift; win[0] is the incoming pixel
  always_comb begin
    win[0] = in_px;
    for (int m = 1; m <= SR_N; m++) win[m] = sr[m-1];
  end

  always_comb begin
    num = '0;
    den = '0;
    w   = '0;
    idx = '0;
    rr  = 0;
    cc  = 0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        rr  = int'(row) + i - R;
        cc  = int'(col) + j - R;
        idx = IW'((KSIZE - 1 - i) * WIDTH + (KSIZE - 1 - j));
        if (rr >= 0 && rr < HEIGHT && cc >= 0 && cc < WIDTH) begin
          w   = wgt(i, j);
          num = num + NUM_W'(win[idx]) * NUM_W'(w);
          den = den + w;
        end
      end
    end
    if (mode_q == 2'b01) den = TOTAL;
    quo    = num / NUM_W'(den);
    blur   = (quo > NUM_W'(PMAX)) ? PMAX : quo[PIXEL_W-1:0];
    result = (mode_q == 2'b10) ? win[D] : blur;
  end

  always_ff @(posedge clock) begin
    if (adv) begin
      for (int m = 0; m < SR_N; m++) sr[m] <= win[m];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      mode_q    <= 2'b00;
      pix_cnt   <= '0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_din   <= '0;
    end else begin
      // mode tracks the pin until the first pop of a frame
      if (state == FILL && pix_cnt == '0) begin
        mode_q <= (mode == 2'b11) ? 2'b00 : mode;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_din   <= result;
        out_last  <= at_end;
        if (col == CW'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (out_wr_en) begin
        out_valid <= 1'b0;
      end
      if (adv) begin
        unique case (1'b1)
          state == FILL: begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == PW'(D - 1)) state <= RUN;
          end
          state == RUN: begin
            if (pix_cnt == PW'(NPIX - 1)) begin
              pix_cnt <= '0;
              state   <= FLUSH;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
          default: begin
            if (at_end) state <= FILL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gaussian_blur_stream.sv
// Scoreboard bench: 8x8 KSIZE=5 and 16x8 KSIZE=3 instances.
// FIFO models on negedge, monitors pop expected writes from queues.
module tb_gaussian_blur_stream;

  localparam int K5T [5][5] = '{'{2, 4, 5, 4, 2}, '{4, 9, 12, 9, 4},
                                '{5, 12, 15, 12, 5}, '{4, 9, 12, 9, 4},
                                '{2, 4, 5, 4, 2}};
  localparam int K3T [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  logic       rd5, wr5, fd5, rd3, wr3, fd3;
  logic       empty5 = 1'b1, full5 = 1'b0, empty3 = 1'b1, full3 = 1'b0;
  logic [7:0] dout5 = '0, din5, dout3 = '0, din3;
  logic [1:0] mode5 = 2'b00, mode3 = 2'b00;
  logic       stall3 = 1'b0;

  logic [7:0] fifo5 [$];
  logic [7:0] fifo3 [$];
  logic [8:0] sb5 [$];
  logic [8:0] sb3 [$];
  int img [8][16];
  int got5 [64];
  int n5 = 0, n3 = 0, nfd5 = 0, nfd3 = 0, pops3 = 0;
  int pop18 = 0, first_wr3 = 0;
  bit seen3 = 1'b0;

  gaussian_blur_stream #(.WIDTH(8), .HEIGHT(8), .PIXEL_W(8), .KSIZE(5)) dut5 (
    .clock(clock), .reset(reset), .in_rd_en(rd5), .in_empty(empty5),
    .in_dout(dout5), .out_wr_en(wr5), .out_full(full5), .out_din(din5),
    .mode(mode5), .frame_done(fd5));

  gaussian_blur_stream #(.WIDTH(16), .HEIGHT(8), .PIXEL_W(8), .KSIZE(3)) dut3 (
    .clock(clock), .reset(reset), .in_rd_en(rd3), .in_empty(empty3),
    .in_dout(dout3), .out_wr_en(wr3), .out_full(full3), .out_din(din3),
    .mode(mode3), .frame_done(fd3));

  function automatic int model(input int h, input int w, input int k,
                               input int m, input int r, input int c);
    int rad, num, den, wt, rr, cc, q;
    rad = (k - 1) / 2;
    num = 0;
    den = 0;
    if (m == 2) return img[r][c];
    for (int dr = -rad; dr <= rad; dr++) begin
      for (int dc = -rad; dc <= rad; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < h && cc >= 0 && cc < w) begin
          if (k == 5) wt = K5T[dr+2][dc+2];
          else wt = K3T[dr+1][dc+1];
          num += img[rr][cc] * wt;
          den += wt;
        end
      end
    end
    if (m == 1) den = (k == 5) ? 159 : 16;
    q = num / den;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic issue(input bit d3, input int h, input int w,
                       input int k, input int m);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        logic [8:0] e;
        e = {(r == h - 1 && c == w - 1), 8'(model(h, w, k, m, r, c))};
        if (d3) begin
          fifo3.push_back(8'(img[r][c]));
          sb3.push_back(e);
        end else begin
          fifo5.push_back(8'(img[r][c]));
          sb5.push_back(e);
        end
      end
    end
  endtask

  task automatic wait_done(input bit d3, input string nm);
    int t;
    t = 0;
    while ((d3 ? sb3.size() : sb5.size()) != 0 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk(nm, d3 ? sb3.size() : sb5.size(), 0);
    repeat (4) @(negedge clock);
  endtask

  // input FIFO models
  initial forever begin
    @(negedge clock);
    empty5 = (fifo5.size() == 0);
    dout5  = empty5 ? 8'd0 : fifo5[0];
    #1;
    if (rd5) begin
      checks++;
      if (empty5) begin
        errors++;
        $display("FAIL rd_when_empty5 got rd=1 want rd=0");
      end else fifo5.delete(0);
    end
  end

  initial forever begin
    @(negedge clock);
    empty3 = (fifo3.size() == 0) || (stall3 && $urandom_range(99) < 30);
    dout3  = (fifo3.size() == 0) ? 8'd0 : fifo3[0];
    full3  = stall3 && ($urandom_range(1) == 1);
    #1;
    if (rd3) begin
      checks++;
      if (empty3) begin
        errors++;
        $display("FAIL rd_when_empty3 got rd=1 want rd=0");
      end else begin
        fifo3.delete(0);
        pops3++;
        if (pops3 == 18) pop18 = cyc;
      end
    end
  end

  // output monitors
  initial forever begin
    logic [8:0] e;
    @(negedge clock);
    #2;
    if (fd5) nfd5++;
    if (wr5) begin
      checks++;
      if (sb5.size() == 0) begin
        errors++;
        $display("FAIL extra_write5 got %0d want none", din5);
      end else begin
        e = sb5.pop_front();
        if (din5 !== e[7:0] || fd5 !== e[8]) begin
          errors++;
          $display("FAIL out5 #%0d got %0d fd%0b want %0d fd%0b",
                   n5, din5, fd5, e[7:0], e[8]);
        end
      end
      got5[6'(n5)] = int'(din5);
      n5++;
    end
  end

  initial forever begin
    logic [8:0] e;
    @(negedge clock);
    #2;
    if (fd3) nfd3++;
    if (wr3) begin
      if (!seen3) begin
        seen3 = 1'b1;
        first_wr3 = cyc;
      end
      checks++;
      if (sb3.size() == 0) begin
        errors++;
        $display("FAIL extra_write3 got %0d want none", din3);
      end else begin
        e = sb3.pop_front();
        if (din3 !== e[7:0] || fd3 !== e[8]) begin
          errors++;
          $display("FAIL out3 #%0d got %0d fd%0b want %0d fd%0b",
                   n3, din3, fd3, e[7:0], e[8]);
        end
      end
      n3++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    #3;
    chk("rst_din5", int'(din5), 0);
    chk("rst_wr5", int'(wr5), 0);
    chk("rst_fd5", int'(fd5), 0);
    chk("rst_rd5", int'(rd5), 0);
    chk("rst_din3", int'(din3), 0);
    chk("rst_wr3", int'(wr3), 0);
    @(negedge clock);
    reset = 1'b0;

    // flat 100 then impulse, back to back, renormalise
    mode5 = 2'b00;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = 100;
    issue(0, 8, 8, 5, 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = (r == 4 && c == 4) ? 255 : 0;
    issue(0, 8, 8, 5, 0);
    wait_done(0, "drain_b2b5");
    chk("writes_b2b5", n5, 128);
    chk("frame_done_b2b5", nfd5, 2);
    chk("imp_4_4", got5[36], 24);
    chk("imp_4_5", got5[37], 19);
    chk("imp_2_2", got5[18], 3);
    chk("imp_0_0", got5[0], 0);

    // flat 255 zero-pad
    mode5 = 2'b01;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = 255;
    issue(0, 8, 8, 5, 1);
    wait_done(0, "drain_zp5");
    chk("zp_corner", got5[0], 109);
    chk("zp_corner_br", got5[63], 109);
    chk("zp_edge_0_3", got5[3], 166);
    chk("zp_interior", got5[36], 255);
    chk("frame_done_zp5", nfd5, 3);

    // reset mid-frame
    mode5 = 2'b00;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = r * 8 + c;
    issue(0, 8, 8, 5, 0);
    repeat (40) @(negedge clock);
    reset = 1'b1;
    #3;
    chk("midrst_din5", int'(din5), 0);
    chk("midrst_wr5", int'(wr5), 0);
    chk("midrst_fd5", int'(fd5), 0);
    chk("midrst_rd5", int'(rd5), 0);
    fifo5.delete();
    sb5.delete();
    n5 = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = (r == 4 && c == 4) ? 255 : 0;
    issue(0, 8, 8, 5, 0);
    wait_done(0, "drain_post_rst5");
    chk("post_rst_writes5", n5, 64);
    chk("post_rst_4_4", got5[36], 24);
    chk("post_rst_fd5", nfd5, 4);

    // ramp bypass, KSIZE=3, latency
    mode3 = 2'b10;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) img[r][c] = r * 16 + c;
    issue(1, 8, 16, 3, 2);
    wait_done(1, "drain_ramp3");
    chk("latency3", first_wr3 - pop18, 1);

    // random frames under random stalls and backpressure
    stall3 = 1'b1;
    for (int m = 0; m < 2; m++) begin
      mode3 = 2'(m);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 16; c++) img[r][c] = int'($urandom_range(255));
      issue(1, 8, 16, 3, m);
      wait_done(1, "drain_bp3");
    end
    stall3 = 1'b0;
    chk("writes3", n3, 384);
    chk("frame_done3", nfd3, 3);

    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
